// File: rtl/serializer_pkg.sv
// Shared types and helpers for the word serializer slice.
//   ser_state_t : serializer FSM state encoding
//   idx_width() : bit-index width for a W-bit word, minimum 1
package serializer_pkg;

    typedef enum logic {ST_IDLE, ST_SHIFT} ser_state_t;

    // Width of an index that addresses bits 0..w-1; a 1-bit word still
    // needs a 1-bit select so the mux tree has at least one level.
    function automatic int idx_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_select_mux.sv
// W-to-1 bit select built as a binary tree of mux2_cell instances.
//   data : W-bit input word
//   sel  : bit index (idx_width(W) bits); sel MSB drives the root level
//   y    : data[sel]
// The word is zero-padded to the next power of two so the tree is full;
// padded leaves are unreachable for legal sel values.
module bit_select_mux
    import serializer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]              data,
    input  logic [idx_width(W)-1:0]   sel,
    output logic                      y
);
    localparam int IW = idx_width(W);
    localparam int P  = 1 << IW;

    // Heap-ordered tree: node 0 is the root, children of i are 2i+1 / 2i+2,
    // leaves occupy P-1 .. 2P-2 in bit order.
    logic [2*P-2:0] node;

    for (genvar j = 0; j < P; j++) begin : g_leaf
        if (j < W) begin : g_real
            assign node[P-1+j] = data[j];
        end else begin : g_pad
            assign node[P-1+j] = 1'b0;
        end
    end

    for (genvar d = 0; d < IW; d++) begin : g_lvl
        for (genvar k = 0; k < (1 << d); k++) begin : g_node
            localparam int I = (1 << d) - 1 + k;
            mux2_cell u_mux (
                .a (node[2*I+1]),
                .b (node[2*I+2]),
                .s (sel[IW-1-d]),
                .y (node[I])
            );
        end
    end

    assign y = node[0];
endmodule

// File: rtl/mux2_cell.sv
// 2:1 mux cell: y = s ? b : a.
//   a, b : data inputs
//   s    : select (1 picks b)
//   y    : output
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: accepts a W-bit word over valid/ready and
// emits it one bit per transfer, LSB or MSB first.
//   clk, rst   : clock, synchronous active-high reset
//   up_valid   : upstream word valid
//   up_data    : upstream word
//   up_ready   : word can be accepted this cycle (combinational from ser_ready)
//   ser_valid  : ser_data holds a valid bit
//   ser_data   : current serial bit
//   ser_last   : current bit is the last of its word
//   ser_ready  : downstream takes the bit this cycle
module word_serializer
    import serializer_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic         ser_valid,
    output logic         ser_data,
    output logic         ser_last,
    input  logic         ser_ready
);
    localparam int IW = idx_width(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    ser_state_t     state_q, state_d;
    logic [W-1:0]   word_q, word_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  sel;
    logic           mux_y;
    logic           word_xfer;
    logic           bit_xfer;

    // Outputs are gated by rst so they read 0 during the reset cycle itself,
    // not only after the first reset edge.
    assign ser_valid = !rst && (state_q == ST_SHIFT);
    assign ser_last  = ser_valid && (idx_q == LAST_IDX);
    assign ser_data  = ser_valid && mux_y;
    // In SHIFT a new word is taken only as the last bit leaves, which is
    // what makes back-to-back words bubble-free.
    assign up_ready  = !rst && ((state_q == ST_IDLE) || (ser_last && ser_ready));

    assign word_xfer = up_valid && up_ready;
    assign bit_xfer  = ser_valid && ser_ready;

    assign sel = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;

    bit_select_mux #(.W(W)) u_sel (
        .data (word_q),
        .sel  (sel),
        .y    (mux_y)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (word_xfer) begin
                    state_d = ST_SHIFT;
                    word_d  = up_data;
                    idx_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (bit_xfer) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else if (word_xfer) begin
                        word_d = up_data;
                        idx_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: an LSB-first and an MSB-first instance share
// all inputs and are compared each cycle against a bits-remaining model.
module tb_word_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_valid;
    logic [W-1:0] up_data;
    logic         ser_ready;

    logic l_ready, l_valid, l_data, l_last;
    logic m_ready, m_valid, m_data, m_last;

    int checks = 0;
    int errors = 0;

    // Model: number of bits of the current word still to be sent, and the word.
    int           cnt = 0;
    logic [W-1:0] m_word = '0;
    int           xfers;

    always #5 clk = ~clk;

    word_serializer #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data),
        .up_ready(l_ready), .ser_valid(l_valid), .ser_data(l_data),
        .ser_last(l_last), .ser_ready(ser_ready)
    );

    word_serializer #(.W(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data),
        .up_ready(m_ready), .ser_valid(m_valid), .ser_data(m_data),
        .ser_last(m_last), .ser_ready(ser_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic sr);
        logic e_rdy, e_vld, e_last, e_lsb, e_msb;
        rst = r; up_valid = v; up_data = d; ser_ready = sr;
        @(negedge clk);
        e_rdy  = !r && (cnt == 0 || (cnt == 1 && sr));
        e_vld  = !r && (cnt > 0);
        e_last = e_vld && (cnt == 1);
        e_lsb  = 1'b0;
        e_msb  = 1'b0;
        if (e_vld) begin
            e_lsb = m_word[W - cnt];
            e_msb = m_word[cnt - 1];
        end
        chk("lsb_up_ready", l_ready, e_rdy);
        chk("lsb_valid",    l_valid, e_vld);
        chk("lsb_last",     l_last,  e_last);
        chk("lsb_data",     l_data,  e_lsb);
        chk("msb_up_ready", m_ready, e_rdy);
        chk("msb_valid",    m_valid, e_vld);
        chk("msb_last",     m_last,  e_last);
        chk("msb_data",     m_data,  e_msb);
        if (l_valid && sr) xfers++;
        @(posedge clk);
        if (r) cnt = 0;
        else if (v && e_rdy) begin
            cnt = W;
            m_word = d;
        end else if (e_vld && sr) cnt--;
        #1;
    endtask

    initial begin
        rst = 1'b1; up_valid = 1'b0; up_data = '0; ser_ready = 1'b0;

        // Reset held with up_valid high: nothing accepted
        repeat (3) step(1'b1, 1'b1, 8'hA5, 1'b1);

        // Single word A5, continuous ready (also covers MSB-first order)
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);

        // MSB/LSB pattern 81
        step(1'b0, 1'b1, 8'h81, 1'b1);
        repeat (9) step(1'b0, 1'b0, 8'h5A, 1'b1);

        // Backpressure 3C with ready pattern 1,0,0,1,...
        step(1'b0, 1'b1, 8'h3C, 1'b1);
        xfers = 0;
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b0, W'($urandom), (i % 3) == 0);
        chk("bp_transfers", xfers, 8);

        // Back-to-back FF then 00, up_valid held high
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, (i < 8) ? 8'h00 : 8'hC3, i < 15);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (9) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Mid-word reset after 3 bits of F0, then 0F from bit 0
        step(1'b0, 1'b1, 8'hF0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h0F, 1'b1);
        repeat (9) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 W'($urandom), $urandom_range(0, 3) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
